// File: rtl/id_ex_stage.sv
// id_ex_stage: ID->EX pipeline buffer feeding the ALU.
// A two-entry skid buffer (MAIN presents to EX, SKID absorbs one extra entry)
// with valid/ready on both sides. in_ready is a register, so it never depends
// combinationally on out_ready. Supports flush and synchronous active-high reset.
// Optional feature macro: IDEX_BYPASS_EN enables writeback forwarding into
// entries at capture time and while they are held.
module id_ex_stage #(
    parameter int BW  = 32,
    parameter int AW  = 4,
    parameter int RAW = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [AW-1:0]  in_aluc,
    input  logic [BW-1:0]  in_num1,
    input  logic [BW-1:0]  in_num2,
    input  logic           in_use1,
    input  logic           in_use2,
    input  logic [RAW-1:0] in_rs1,
    input  logic [RAW-1:0] in_rs2,
    input  logic [RAW-1:0] in_rd,
    input  logic           in_wen,
    input  logic [BW-1:0]  in_pc,
    input  logic           wb_wen,
    input  logic [RAW-1:0] wb_rd,
    input  logic [BW-1:0]  wb_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [AW-1:0]  out_aluc,
    output logic [BW-1:0]  out_num1,
    output logic [BW-1:0]  out_num2,
    output logic [RAW-1:0] out_rd,
    output logic           out_wen,
    output logic [BW-1:0]  out_pc
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [AW-1:0]  aluc;
        logic [BW-1:0]  num1;
        logic [BW-1:0]  num2;
        logic [RAW-1:0] rd;
        logic           wen;
        logic [BW-1:0]  pc;
`ifdef IDEX_BYPASS_EN
        logic           use1;
        logic           use2;
        logic [RAW-1:0] rs1;
        logic [RAW-1:0] rs2;
`endif
    } entry_t;

    state_t state;
    state_t state_nxt;
    logic   in_ready_r;
    entry_t main_q;
    entry_t skid_q;
    entry_t in_entry;
    entry_t main_fwd;
    entry_t skid_fwd;
    logic   in_fire;
    logic   out_fire;

`ifdef IDEX_BYPASS_EN
    // Replace a register-sourced operand with the writeback value when the
    // writeback targets that register; x0 is never forwarded.
    function automatic entry_t fwd(input entry_t e, input logic w_en,
                                   input logic [RAW-1:0] w_rd, input logic [BW-1:0] w_data);
        entry_t r;
        r = e;
        if (w_en && (w_rd != '0)) begin
            if (e.use1 && (e.rs1 == w_rd)) r.num1 = w_data;
            if (e.use2 && (e.rs2 == w_rd)) r.num2 = w_data;
        end
        return r;
    endfunction
`else
    logic unused_bypass;
    assign unused_bypass = ^{wb_wen, wb_rd, wb_data, in_rs1, in_rs2, in_use1, in_use2};
`endif

    assign in_ready  = in_ready_r;
    assign out_valid = (state != EMPTY);
    assign in_fire   = in_valid & in_ready_r;
    assign out_fire  = out_valid & out_ready;

    assign out_aluc = main_q.aluc;
    assign out_num1 = main_q.num1;
    assign out_num2 = main_q.num2;
    assign out_rd   = main_q.rd;
    assign out_wen  = main_q.wen;
    assign out_pc   = main_q.pc;

    // Build the entry to capture and the forwarded views of the held entries.
    always_comb begin
        in_entry      = '0;
        in_entry.aluc = in_aluc;
        in_entry.num1 = in_num1;
        in_entry.num2 = in_num2;
        in_entry.rd   = in_rd;
        in_entry.wen  = in_wen & (in_rd != '0);
        in_entry.pc   = in_pc;
`ifdef IDEX_BYPASS_EN
        in_entry.use1 = in_use1;
        in_entry.use2 = in_use2;
        in_entry.rs1  = in_rs1;
        in_entry.rs2  = in_rs2;
        in_entry      = fwd(in_entry, wb_wen, wb_rd, wb_data);
        main_fwd      = fwd(main_q, wb_wen, wb_rd, wb_data);
        skid_fwd      = fwd(skid_q, wb_wen, wb_rd, wb_data);
`else
        main_fwd      = main_q;
        skid_fwd      = skid_q;
`endif
    end

    // Occupancy transitions; flush empties the buffer regardless of transfers.
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: if (in_fire) state_nxt = ONE;
            ONE: begin
                if (in_fire && !out_fire)      state_nxt = FULL;
                else if (!in_fire && out_fire) state_nxt = EMPTY;
            end
            FULL: if (out_fire) state_nxt = ONE;
            default: state_nxt = EMPTY;
        endcase
        if (flush) state_nxt = EMPTY;
    end

    // State, registered in_ready and entry storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            in_ready_r <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else begin
            state      <= state_nxt;
            in_ready_r <= (state_nxt != FULL);
            main_q     <= main_fwd;
            skid_q     <= skid_fwd;
            if (!flush) begin
                case (state)
                    EMPTY: if (in_fire) main_q <= in_entry;
                    ONE: begin
                        if (in_fire && out_fire) main_q <= in_entry;
                        else if (in_fire)        skid_q <= in_entry;
                    end
                    FULL: if (out_fire) main_q <= skid_fwd;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage: directed stimulus, scoreboard queue of expected
// output entries, and an independent monitor that pops on each out transfer.
module tb_id_ex_stage;

`ifdef IDEX_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_aluc;
    logic [31:0] in_num1;
    logic [31:0] in_num2;
    logic        in_use1;
    logic        in_use2;
    logic [3:0]  in_rs1;
    logic [3:0]  in_rs2;
    logic [3:0]  in_rd;
    logic        in_wen;
    logic [31:0] in_pc;
    logic        wb_wen;
    logic [3:0]  wb_rd;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_aluc;
    logic [31:0] out_num1;
    logic [31:0] out_num2;
    logic [3:0]  out_rd;
    logic        out_wen;
    logic [31:0] out_pc;

    typedef struct packed {
        logic [3:0]  aluc;
        logic [31:0] num1;
        logic [31:0] num2;
        logic [3:0]  rd;
        logic        wen;
        logic [31:0] pc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    id_ex_stage #(.BW(32), .AW(4), .RAW(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_aluc(in_aluc), .in_num1(in_num1), .in_num2(in_num2),
        .in_use1(in_use1), .in_use2(in_use2), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_rd(in_rd), .in_wen(in_wen), .in_pc(in_pc),
        .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_aluc(out_aluc), .out_num1(out_num1), .out_num2(out_num2),
        .out_rd(out_rd), .out_wen(out_wen), .out_pc(out_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Monitor: every out transfer must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
            exp_t act;
            exp_t e;
            act = {out_aluc, out_num1, out_num2, out_rd, out_wen, out_pc};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got %h, expected no entry", act);
            end else begin
                e = exp_q.pop_front();
                if (act !== e) begin
                    errors++;
                    $display("FAIL out_entry: got aluc=%h n1=%h n2=%h rd=%h wen=%b pc=%h, expected aluc=%h n1=%h n2=%h rd=%h wen=%b pc=%h",
                             act.aluc, act.num1, act.num2, act.rd, act.wen, act.pc,
                             e.aluc, e.num1, e.num2, e.rd, e.wen, e.pc);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one entry; the expectation is queued when the DUT accepts it.
    task automatic push(input logic [3:0] aluc, input logic [31:0] n1, input logic [31:0] n2,
                        input logic [3:0] rd, input logic wen, input logic [31:0] pc,
                        input logic u1, input logic u2, input logic [3:0] rs1, input logic [3:0] rs2,
                        input logic [31:0] e1, input logic [31:0] e2);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_aluc = aluc; in_num1 = n1; in_num2 = n2; in_rd = rd; in_wen = wen; in_pc = pc;
        in_use1 = u1; in_use2 = u2; in_rs1 = rs1; in_rs2 = rs2;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) ok = 1'b1;
            else tick();
        end
        if (ok) begin
            tick();
            exp_q.push_back({aluc, e1, e2, rd, wen & (rd != 4'd0), pc});
        end else begin
            checks++;
            errors++;
            $display("FAIL push_timeout: got in_ready=0 for 20 cycles, expected 1");
        end
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_aluc = '0; in_num1 = '0; in_num2 = '0; in_use1 = 1'b0; in_use2 = 1'b0;
        in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_wen = 1'b0; in_pc = '0;
        wb_wen = 1'b0; wb_rd = '0; wb_data = '0;

        // Reset
        repeat (2) tick();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_num1", out_num1, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        chk("rst_in_ready_release_edge", {31'd0, in_ready}, 32'd0);
        tick();
        chk("in_ready_after_release", {31'd0, in_ready}, 32'd1);

        // Single ADD, one-cycle latency
        out_ready = 1'b1;
        push(4'd0, 32'd5, 32'd7, 4'd3, 1'b1, 32'h100, 1'b0, 1'b0, 4'd0, 4'd0, 32'd5, 32'd7);
        chk("lat_out_valid", {31'd0, out_valid}, 32'd1);
        chk("lat_out_num1", out_num1, 32'd5);
        chk("lat_out_num2", out_num2, 32'd7);
        chk("lat_out_rd", {28'd0, out_rd}, 32'd3);
        tick();

        // Fill to FULL, hold, then drain in order
        out_ready = 1'b0;
        push(4'd1, 32'hA1, 32'hA2, 4'd5, 1'b1, 32'h104, 1'b0, 1'b0, 4'd0, 4'd0, 32'hA1, 32'hA2);
        push(4'd2, 32'hB1, 32'hB2, 4'd6, 1'b1, 32'h108, 1'b0, 1'b0, 4'd0, 4'd0, 32'hB1, 32'hB2);
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        chk("full_head", out_num1, 32'hA1);
        repeat (2) tick();
        chk("hold_valid", {31'd0, out_valid}, 32'd1);
        chk("hold_stable", out_num1, 32'hA1);
        out_ready = 1'b1;
        repeat (3) tick();
        chk("drain_in_ready", {31'd0, in_ready}, 32'd1);
        chk("drain_empty", {31'd0, out_valid}, 32'd0);

        // Flush from FULL with a dropped input
        out_ready = 1'b0;
        push(4'd3, 32'hC1, 32'hC2, 4'd7, 1'b1, 32'h10C, 1'b0, 1'b0, 4'd0, 4'd0, 32'hC1, 32'hC2);
        push(4'd4, 32'hD1, 32'hD2, 4'd8, 1'b1, 32'h110, 1'b0, 1'b0, 4'd0, 4'd0, 32'hD1, 32'hD2);
        in_valid = 1'b1; in_num1 = 32'hE1; in_rd = 4'd9; flush = 1'b1;
        exp_q.delete();
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_full_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_in_ready", {31'd0, in_ready}, 32'd1);

        // Flush from ONE while in_ready=1 and in_valid=1
        push(4'd5, 32'hF1, 32'hF2, 4'd10, 1'b1, 32'h114, 1'b0, 1'b0, 4'd0, 4'd0, 32'hF1, 32'hF2);
        in_valid = 1'b1; in_num1 = 32'h61; in_rd = 4'd11; flush = 1'b1;
        exp_q.delete();
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_one_valid", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1;
        repeat (3) tick();
        chk("flush_no_ghost", {31'd0, out_valid}, 32'd0);

        // x0 destination never written
        push(4'd6, 32'h1, 32'h2, 4'd0, 1'b1, 32'h118, 1'b0, 1'b0, 4'd0, 4'd0, 32'h1, 32'h2);
        chk("rd0_wen", {31'd0, out_wen}, 32'd0);
        push(4'd7, 32'h3, 32'h4, 4'd9, 1'b1, 32'h11C, 1'b0, 1'b0, 4'd0, 4'd0, 32'h3, 32'h4);
        chk("rd9_wen", {31'd0, out_wen}, 32'd1);
        repeat (2) tick();

        // Forwarding into a held MAIN entry
        out_ready = 1'b0;
        push(4'd0, 32'h10, 32'h5, 4'd1, 1'b1, 32'h120, 1'b1, 1'b0, 4'd4, 4'd0,
             BYP ? 32'hAB : 32'h10, 32'h5);
        wb_wen = 1'b1; wb_rd = 4'd4; wb_data = 32'hAB;
        tick();
        wb_wen = 1'b0;
        chk("byp_main", out_num1, BYP ? 32'hAB : 32'h10);
        out_ready = 1'b1;
        repeat (2) tick();

        // Writeback to x0 must not forward
        out_ready = 1'b0;
        push(4'd0, 32'h20, 32'h6, 4'd2, 1'b1, 32'h124, 1'b1, 1'b0, 4'd0, 4'd0, 32'h20, 32'h6);
        wb_wen = 1'b1; wb_rd = 4'd0; wb_data = 32'hCD;
        tick();
        wb_wen = 1'b0;
        chk("byp_x0", out_num1, 32'h20);
        out_ready = 1'b1;
        repeat (2) tick();

        // Forwarding at capture time
        out_ready = 1'b0;
        wb_wen = 1'b1; wb_rd = 4'd7; wb_data = 32'h77;
        push(4'd0, 32'h30, 32'h1, 4'd3, 1'b1, 32'h128, 1'b0, 1'b1, 4'd0, 4'd7,
             32'h30, BYP ? 32'h77 : 32'h1);
        wb_wen = 1'b0;
        chk("byp_capture", out_num2, BYP ? 32'h77 : 32'h1);
        out_ready = 1'b1;
        repeat (2) tick();

        // Forwarding into both MAIN and SKID; use flag gates the match
        out_ready = 1'b0;
        push(4'd0, 32'h11, 32'h33, 4'd4, 1'b1, 32'h12C, 1'b1, 1'b0, 4'd2, 4'd2,
             BYP ? 32'h55 : 32'h11, 32'h33);
        push(4'd0, 32'h44, 32'h22, 4'd5, 1'b1, 32'h130, 1'b0, 1'b1, 4'd0, 4'd2,
             32'h44, BYP ? 32'h55 : 32'h22);
        wb_wen = 1'b1; wb_rd = 4'd2; wb_data = 32'h55;
        tick();
        wb_wen = 1'b0;
        chk("byp_full_main", out_num1, BYP ? 32'h55 : 32'h11);
        chk("byp_full_use2_off", out_num2, 32'h33);
        out_ready = 1'b1;
        repeat (4) tick();

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
